// File: rtl/prirv32_fetch_resp_pkg.sv
// Shared core definitions for the instruction fetch responder: FSM encoding,
// error-bit positions, the NOP filler word and the fetch error classifier.
package prirv32_fetch_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fetch_state_e;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;
  localparam int CNT_W        = 3;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic logic [1:0] fetch_err(input logic [31:0] addr, input int unsigned depth);
    logic [1:0] err;
    err               = 2'b00;
    err[ERR_MISALIGN] = |addr[1:0];
    err[ERR_RANGE]    = ({2'b00, addr[31:2]} >= depth);
    return err;
  endfunction

endpackage

// File: rtl/prirv32_fetch_resp_if.sv
// Fetch request/response, redirect and program-load signals between the IFU
// (master) and the instruction responder (slave).
interface prirv32_fetch_resp_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        flush_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [31:0] rsp_addr_o;
  logic [1:0]  rsp_err_o;
  logic        ld_we_i;
  logic [31:0] ld_addr_i;
  logic [31:0] ld_data_i;

  modport master (
    output req_valid_i, req_addr_i, flush_i, rsp_ready_i, ld_we_i, ld_addr_i, ld_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_addr_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, flush_i, rsp_ready_i, ld_we_i, ld_addr_i, ld_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_addr_o, rsp_err_o
  );
endinterface

// File: rtl/prirv32_imem_array.sv
// Instruction store: one write port, one registered read port. Contents are
// never reset; a same-cycle write/read of one word returns the old word.
module prirv32_imem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/prirv32_fetch_resp.sv
// Single-outstanding instruction fetch responder: accepts one PC, waits a fixed
// number of cycles, then returns the instruction word (or a NOP on error).
module prirv32_fetch_resp
  import prirv32_fetch_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ERR_INSN    = NOP_INSN
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  prirv32_fetch_resp_if.slave  bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  fetch_state_e     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      addr_reg;
  logic [1:0]       err_reg;
  logic             req_ready;
  logic             handshake;
  logic [1:0]       req_err;
  logic             rd_en;
  logic [AW-1:0]    rd_idx;
  logic [31:0]      rd_data;
  logic             ld_in_range;
  logic             rsp_valid;
  logic             unused_ld_lsbs;

  assign req_ready = !bus.flush_i &&
                     ((state_reg == ST_IDLE) || ((state_reg == ST_RESP) && bus.rsp_ready_i));
  assign handshake = bus.req_valid_i && req_ready;
  assign req_err   = fetch_err(bus.req_addr_i, DEPTH_WORDS);

  // The store is read on the edge that enters RESP, so its registered output
  // lines up with rsp_valid_o; erroneous fetches never touch the array.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rd_en      = 1'b0;
    rd_idx     = addr_reg[AW+1:2];
    if (bus.flush_i) begin
      state_next = ST_IDLE;
    end else if (handshake) begin
      cnt_next = WAIT_LOAD;
      if (WAIT_CYCLES == 0) begin
        state_next = ST_RESP;
        rd_en      = (req_err == 2'b00);
        rd_idx     = bus.req_addr_i[AW+1:2];
      end else begin
        state_next = ST_WAIT;
      end
    end else begin
      unique case (state_reg)
        ST_WAIT: begin
          if (cnt_reg == '0) begin
            state_next = ST_RESP;
            rd_en      = (err_reg == 2'b00);
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        ST_RESP: if (bus.rsp_ready_i) state_next = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (handshake) begin
        addr_reg <= bus.req_addr_i;
        err_reg  <= req_err;
      end
    end
  end

  assign ld_in_range    = ({2'b00, bus.ld_addr_i[31:2]} < 32'(DEPTH_WORDS));
  assign unused_ld_lsbs = ^bus.ld_addr_i[1:0];

  prirv32_imem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_imem (
    .clk   (clk_i),
    .we    (bus.ld_we_i && ld_in_range),
    .waddr (bus.ld_addr_i[AW+1:2]),
    .wdata (bus.ld_data_i),
    .re    (rd_en),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  // Data is gated by state so reset zeroes it without resetting the array.
  assign rsp_valid       = (state_reg == ST_RESP);
  assign bus.req_ready_o = req_ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_data_o  = !rsp_valid ? 32'h0 : ((err_reg != 2'b00) ? ERR_INSN : rd_data);
  assign bus.rsp_addr_o  = addr_reg;
  assign bus.rsp_err_o   = err_reg;

endmodule

// File: tb/tb_prirv32_fetch_resp.sv
// Directed bench for prirv32_fetch_resp: latency, errors, backpressure,
// back-to-back, flush, reset and load/read collision.
module tb_prirv32_fetch_resp;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  prirv32_fetch_resp_if bus ();

  prirv32_fetch_resp #(
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (1),
    .ERR_INSN    (32'h0000_0013)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    bus.ld_we_i   = 1'b1;
    bus.ld_addr_i = a;
    bus.ld_data_i = d;
    @(negedge clk);
    bus.ld_we_i = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.rsp_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid_o) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: rsp_valid_o=%b after %0d cycles, required 1", bus.rsp_valid_o, n);
    end else begin
      $display("rsp addr=%h data=%h err=%b after %0d cycles", bus.rsp_addr_o, bus.rsp_data_o, bus.rsp_err_o, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_addr_o, bus.rsp_err_o} !== 67'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h addr=%h err=%b, required all 0",
               bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_addr_o, bus.rsp_err_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready_o=%b, required 1", bus.req_ready_o);
    end
  endtask

  task automatic test_load_range;
    int n;
    issue(32'h0);
    wait_valid(n);
    checks++;
    if (bus.rsp_data_o !== 32'h0A0A_0A0A || bus.rsp_err_o !== 2'b00) begin
      errors++;
      $display("FAIL word0_not_clobbered: data=%h err=%b, required 0a0a0a0a 00", bus.rsp_data_o, bus.rsp_err_o);
    end
    @(negedge clk);
    issue(32'h0000_0FFC);
    wait_valid(n);
    checks++;
    if (bus.rsp_data_o !== 32'h7777_0001 || bus.rsp_err_o !== 2'b00) begin
      errors++;
      $display("FAIL last_word: data=%h err=%b, required 77770001 00", bus.rsp_data_o, bus.rsp_err_o);
    end
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n;
    issue(32'h10);
    wait_valid(n);
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL basic_latency: %0d cycles, required %0d", n, LAT);
    end
    checks++;
    if (bus.rsp_data_o !== 32'h0050_0093 || bus.rsp_addr_o !== 32'h10 || bus.rsp_err_o !== 2'b00) begin
      errors++;
      $display("FAIL basic_rsp: data=%h addr=%h err=%b, required 00500093 00000010 00",
               bus.rsp_data_o, bus.rsp_addr_o, bus.rsp_err_o);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_consumed: rsp_valid_o=%b, required 0", bus.rsp_valid_o);
    end
  endtask

  task automatic test_errors;
    int n;
    logic [31:0] addrs [3];
    logic [1:0]  errs  [3];
    addrs = '{32'h12, 32'h1000, 32'h1002};
    errs  = '{2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      issue(addrs[i]);
      wait_valid(n);
      checks++;
      if (bus.rsp_data_o !== 32'h13 || bus.rsp_err_o !== errs[i] || bus.rsp_addr_o !== addrs[i]) begin
        errors++;
        $display("FAIL err_%0d: data=%h err=%b addr=%h, required 00000013 %b %h",
                 i, bus.rsp_data_o, bus.rsp_err_o, bus.rsp_addr_o, errs[i], addrs[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    bus.rsp_ready_i = 1'b0;
    issue(32'h18);
    wait_valid(n);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_addr_o, bus.rsp_err_o, bus.req_ready_o} !==
          {1'b1, 32'hAAAA_5555, 32'h18, 2'b00, 1'b0}) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b data=%h addr=%h err=%b ready=%b, required 1 aaaa5555 00000018 00 0",
                 i, bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_addr_o, bus.rsp_err_o, bus.req_ready_o);
      end
    end
    bus.rsp_ready_i = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h14;
    #1;
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: req_ready_o=%b, required 1", bus.req_ready_o);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    wait_valid(n);
    checks++;
    if (n !== LAT || bus.rsp_data_o !== 32'h1234_5678 || bus.rsp_addr_o !== 32'h14) begin
      errors++;
      $display("FAIL b2b_rsp: %0d cycles data=%h addr=%h, required %0d 12345678 00000014",
               n, bus.rsp_data_o, bus.rsp_addr_o, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    int n;
    bit seen;
    issue(32'h18);
    bus.flush_i = 1'b1;
    #1;
    checks++;
    if (bus.req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: req_ready_o=%b, required 0", bus.req_ready_o);
    end
    @(negedge clk);
    bus.flush_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid_o) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_wait: rsp_valid_o seen=%b, required 0", seen);
    end
    issue(32'h20);
    wait_valid(n);
    checks++;
    if (n !== LAT || bus.rsp_data_o !== 32'hCAFE_F00D || bus.rsp_addr_o !== 32'h20) begin
      errors++;
      $display("FAIL after_flush: %0d cycles data=%h addr=%h, required %0d cafef00d 00000020",
               n, bus.rsp_data_o, bus.rsp_addr_o, LAT);
    end
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    issue(32'h10);
    wait_valid(n);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_resp: rsp_valid_o=%b, required 0", bus.rsp_valid_o);
    end
    bus.rsp_ready_i = 1'b1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    issue(32'h10);
    wait_valid(n);
    checks++;
    if (n !== LAT || bus.rsp_data_o !== 32'h0050_0093) begin
      errors++;
      $display("FAIL flush_idle: %0d cycles data=%h, required %0d 00500093", n, bus.rsp_data_o, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_resp;
    int n;
    bus.rsp_ready_i = 1'b0;
    issue(32'h18);
    wait_valid(n);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_addr_o, bus.rsp_err_o} !== 67'h0) begin
      errors++;
      $display("FAIL reset_in_resp: valid=%b data=%h addr=%h err=%b, required all 0",
               bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_addr_o, bus.rsp_err_o);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: ready=%b valid=%b, required 1 0", bus.req_ready_o, bus.rsp_valid_o);
    end
    issue(32'h10);
    wait_valid(n);
    checks++;
    if (n !== LAT || bus.rsp_data_o !== 32'h0050_0093 || bus.rsp_addr_o !== 32'h10) begin
      errors++;
      $display("FAIL after_reset: %0d cycles data=%h addr=%h, required %0d 00500093 00000010",
               n, bus.rsp_data_o, bus.rsp_addr_o, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_ld_collision;
    int n;
    issue(32'h14);
    @(negedge clk);
    bus.ld_we_i   = 1'b1;
    bus.ld_addr_i = 32'h14;
    bus.ld_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.ld_we_i = 1'b0;
    checks++;
    if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL collision_old: valid=%b data=%h, required 1 12345678", bus.rsp_valid_o, bus.rsp_data_o);
    end
    @(negedge clk);
    issue(32'h14);
    wait_valid(n);
    checks++;
    if (bus.rsp_data_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL collision_new: data=%h, required deadbeef", bus.rsp_data_o);
    end
    @(negedge clk);
  endtask

  initial begin
    rst             = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 32'h0;
    bus.flush_i     = 1'b0;
    bus.rsp_ready_i = 1'b1;
    bus.ld_we_i     = 1'b0;
    bus.ld_addr_i   = 32'h0;
    bus.ld_data_i   = 32'h0;
    test_reset;
    load(32'h0,        32'h0A0A_0A0A);
    load(32'h10,       32'h0050_0093);
    load(32'h14,       32'h1234_5678);
    load(32'h18,       32'hAAAA_5555);
    load(32'h20,       32'hCAFE_F00D);
    load(32'h0000_0FFC, 32'h7777_0001);
    load(32'h0000_1000, 32'hBADB_AD00);
    test_load_range;
    test_basic;
    test_errors;
    test_back_to_back;
    test_flush;
    test_reset_resp;
    test_ld_collision;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prirv32_fetch_resp.md
PRIRV32_FETCH_RESP -- requirements
Module: prirv32_fetch_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: instruction store size in 32-bit words, power of two.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, legal 0..7: extra cycles between request acceptance and response.
REQ-003 SHALL have parameter ERR_INSN, default 32'h00000013 (NOP): data returned on error.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid_i, input, 1: fetch request from the IFU.
REQ-007 SHALL have port req_ready_o, output, 1: responder accepts the request this cycle.
REQ-008 SHALL have port req_addr_i, input, 32: byte address of the fetch (the PC).
REQ-009 SHALL have port flush_i, input, 1: branch redirect; discards any in-flight fetch.
REQ-010 SHALL have port rsp_valid_o, output, 1: response valid.
REQ-011 SHALL have port rsp_ready_i, input, 1: IFU consumes the response.
REQ-012 SHALL have port rsp_data_o, output, 32: instruction word.
REQ-013 SHALL have port rsp_addr_o, output, 32: echo of the accepted req_addr_i.
REQ-014 SHALL have port rsp_err_o, output, 2: bit0 misaligned (addr[1:0]!=0), bit1 out of range (word index >= DEPTH_WORDS).
REQ-015 SHALL have ports ld_we_i (input, 1), ld_addr_i (input, 32), ld_data_i (input, 32): word-write port for program load.

Function
REQ-016 SHALL implement FSM IDLE, WAIT, RESP; reset state IDLE.
REQ-017 SHALL drive req_ready_o = !flush_i & (IDLE | (RESP & rsp_ready_i)).
REQ-018 On handshake (req_valid_i & req_ready_o), SHALL capture addr, load wait counter with WAIT_CYCLES, and enter WAIT (or RESP directly when WAIT_CYCLES=0).
REQ-019 In WAIT, SHALL decrement the counter each cycle and enter RESP on the cycle after it reads 0; handshake-to-rsp_valid latency = WAIT_CYCLES+1 cycles.
REQ-020 SHALL read the store on the WAIT->RESP transition and register the result; rsp_data_o/rsp_addr_o/rsp_err_o SHALL hold stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-021 On either error bit set, SHALL return rsp_data_o=ERR_INSN and SHALL NOT index the store.
REQ-022 RESP & rsp_ready_i without a new handshake SHALL go to IDLE; with a new handshake the same cycle SHALL go to WAIT/RESP (back-to-back, no bubble beyond latency).
REQ-023 flush_i in WAIT or RESP SHALL go to IDLE next cycle with rsp_valid_o=0; no response for the discarded fetch is ever produced; flush_i in IDLE SHALL have no effect.
REQ-024 Exactly one request SHALL be outstanding at any time.
REQ-025 ld_we_i SHALL write ld_data_i to word ld_addr_i[31:2] (ignored if out of range) in any state; a write and a read of the same word in one cycle SHALL return the old word.

Reset
REQ-026 rst_i SHALL immediately force state IDLE, counter 0, rsp_valid_o=0, rsp_data_o=0, rsp_addr_o=0, rsp_err_o=0; store contents are not reset.
REQ-027 Reset mid-WAIT/RESP SHALL drop the fetch; first handshake after rst_i deassertion behaves as from IDLE.

Structure
REQ-028 State encoding, error bit indices and the NOP constant SHALL live in the shared core package used by IFU/EXU.
REQ-029 The store SHALL be one sub-module, prirv32_imem_array (1 write port, 1 registered read port).

Verification
REQ-030 WAIT_CYCLES=1, store[4]=0x00500093, request 0x10 -> rsp_valid_o 2 cycles later, data 0x00500093, addr 0x10, err 0.
REQ-031 Request 0x12 -> data 0x00000013, err 2'b01; request 0x1000 with DEPTH_WORDS=1024 -> err 2'b10.
REQ-032 rsp_ready_i low 3 cycles -> outputs stable; then high with req_valid_i at 0x14 -> next response for 0x14 with no extra bubble.
REQ-033 flush_i in WAIT -> no rsp_valid_o for that fetch; next request 0x20 responds normally.
REQ-034 rst_i asserted during RESP -> rsp_valid_o=0 and outputs zero immediately, state IDLE.
REQ-035 ld_we_i to word 5 with value 0xDEADBEEF in the same cycle as the read of word 5 -> old value returned; a later fetch of 0x14 -> 0xDEADBEEF.
